// File: rtl/clk_ctrl_pkg.sv
// Shared types and default constants for the clock-fail select controller.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOCAL   = 2'd0,
    ST_EXT     = 2'd1,
    ST_HOLDOFF = 2'd2
  } clk_state_e;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_WIN_CYC  = 1000;
  localparam int unsigned DEF_TGL_MIN  = 100;
  localparam int unsigned DEF_TGL_MAX  = 300;
  localparam int unsigned DEF_GOOD_WIN = 4;
  localparam int unsigned DEF_HOLD_WIN = 8;

endpackage

// File: rtl/clk_win_meter.sv
// Measures external-clock toggle activity over fixed windows of clk_i cycles.
// win_end marks the terminal cycle; count/good describe the closing window,
// including any event arriving in that terminal cycle.
module clk_win_meter
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned WIN_CYC = DEF_WIN_CYC,
  parameter int unsigned TGL_MIN = DEF_TGL_MIN,
  parameter int unsigned TGL_MAX = DEF_TGL_MAX
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             ext_tgl_i,
  output logic             win_end,
  output logic [CNT_W-1:0] count,
  output logic             good
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(TGL_MIN);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(TGL_MAX);

  logic             s1, s2, s3;
  logic             ev;
  logic             inc;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] tgl_cnt;

  // Three-flop synchronizer; the last stage only serves edge detection.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ext_tgl_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev      = s2 ^ s3;
  assign win_end = (win_cnt == WIN_LAST);
  assign inc     = ev & ~(&tgl_cnt);
  assign count   = tgl_cnt + CNT_W'(inc);
  assign good    = (count >= MIN_C) && (count <= MAX_C);

  // Free-running window counter, 0..WIN_CYC-1.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)    win_cnt <= '0;
    else if (win_end) win_cnt <= '0;
    else              win_cnt <= win_cnt + CNT_W'(1);
  end

  // Saturating toggle counter; clears at window end so a terminal-cycle event is not carried over.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)    tgl_cnt <= '0;
    else if (win_end) tgl_cnt <= '0;
    else              tgl_cnt <= count;
  end

endmodule

// File: rtl/clk_fail_sel_ctrl.sv
// Registered clock-select generator for a BUFGMUX-style selector: qualifies the
// external clock over repeated good windows, falls back on a bad window, then
// holds off before requalifying. Software force overrides the select output.
module clk_fail_sel_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WIN_CYC  = DEF_WIN_CYC,
  parameter int unsigned TGL_MIN  = DEF_TGL_MIN,
  parameter int unsigned TGL_MAX  = DEF_TGL_MAX,
  parameter int unsigned GOOD_WIN = DEF_GOOD_WIN,
  parameter int unsigned HOLD_WIN = DEF_HOLD_WIN
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             ext_tgl_i,
  input  logic             force_en_i,
  input  logic             force_sel_i,
  output logic             sel_o,
  output logic             ext_ok_o,
  output logic [CNT_W-1:0] tgl_cnt_o,
  output logic [1:0]       state_o,
  output logic             switch_p_o
);

  localparam int unsigned GW = $clog2(GOOD_WIN + 1);
  localparam int unsigned HW = $clog2(HOLD_WIN + 1);
  localparam logic [GW-1:0] GOOD_LIM = GW'(GOOD_WIN);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_WIN);

  logic             win_end;
  logic [CNT_W-1:0] count;
  logic             good;

  clk_state_e       state_q, state_d;
  logic [GW-1:0]    good_q, good_d, good_inc;
  logic [HW-1:0]    hold_q, hold_d;
  logic             sel_q, sel_d;
  logic             sw_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ok_q;

  clk_win_meter #(
    .CNT_W   (CNT_W),
    .WIN_CYC (WIN_CYC),
    .TGL_MIN (TGL_MIN),
    .TGL_MAX (TGL_MAX)
  ) u_meter (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .ext_tgl_i (ext_tgl_i),
    .win_end   (win_end),
    .count     (count),
    .good      (good)
  );

  // Next-state logic: qualification, fallback and hold-off, stepped at window end.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    hold_d   = hold_q;
    good_inc = good_q + GW'(1);
    case (state_q)
      ST_LOCAL: begin
        if (win_end) begin
          if (!good) begin
            good_d = '0;
          end else if (good_inc == GOOD_LIM) begin
            state_d = ST_EXT;
            good_d  = '0;
          end else begin
            good_d = good_inc;
          end
        end
      end
      ST_EXT: begin
        if (win_end && !good) begin
          state_d = ST_HOLDOFF;
          hold_d  = HOLD_LIM;
        end
      end
      ST_HOLDOFF: begin
        if (win_end) begin
          hold_d = hold_q - HW'(1);
          if (hold_d == '0) begin
            state_d = ST_LOCAL;
            good_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_LOCAL;
        good_d  = '0;
        hold_d  = '0;
      end
    endcase
    // Select is derived from the next state so it moves together with state_o.
    sel_d = force_en_i ? force_sel_i : (state_d == ST_EXT);
  end

  // FSM, select, switch pulse and latched window status registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_LOCAL;
      good_q  <= '0;
      hold_q  <= '0;
      sel_q   <= 1'b0;
      sw_q    <= 1'b0;
      cnt_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      sw_q    <= sel_d ^ sel_q;
      if (win_end) begin
        cnt_q <= count;
        ok_q  <= good;
      end
    end
  end

  assign sel_o      = sel_q;
  assign switch_p_o = sw_q;
  assign tgl_cnt_o  = cnt_q;
  assign ext_ok_o   = ok_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_clk_fail_sel_ctrl.sv
// Directed bench for clk_fail_sel_ctrl with a 100-cycle window.
module tb_clk_fail_sel_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             ext_tgl = 1'b0;
  logic             force_en = 1'b0;
  logic             force_sel = 1'b0;
  logic             sel_o;
  logic             ext_ok_o;
  logic [CNT_W-1:0] tgl_cnt_o;
  logic [1:0]       state_o;
  logic             switch_p_o;

  int checks = 0;
  int passed = 0;
  int pulse_cnt = 0;
  int pulse_base = 0;

  clk_fail_sel_ctrl #(
    .CNT_W    (CNT_W),
    .WIN_CYC  (100),
    .TGL_MIN  (10),
    .TGL_MAX  (30),
    .GOOD_WIN (3),
    .HOLD_WIN (2)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .ext_tgl_i   (ext_tgl),
    .force_en_i  (force_en),
    .force_sel_i (force_sel),
    .sel_o       (sel_o),
    .ext_ok_o    (ext_ok_o),
    .tgl_cnt_o   (tgl_cnt_o),
    .state_o     (state_o),
    .switch_p_o  (switch_p_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (switch_p_o === 1'b1) pulse_cnt++;

  // One full window (100 negedges) with n toggles every 3 cycles; optional
  // extra toggle whose event lands in the terminal cycle. Returns just after
  // the window-end edge has updated the outputs.
  task automatic run_win(input int n, input bit last);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((i % 3 == 0 && i / 3 < n) || (last && i == 96)) ext_tgl = ~ext_tgl;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    arst_n = 1'b1;
    pulse_base = pulse_cnt;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (sel_o !== 1'b0) $display("FAIL rst_sel: got %b want 0", sel_o); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else passed++;
    checks++; if (tgl_cnt_o !== 16'd0) $display("FAIL rst_tgl: got %0d want 0", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b0) $display("FAIL rst_ok: got %b want 0", ext_ok_o); else passed++;
    checks++; if (switch_p_o !== 1'b0) $display("FAIL rst_sw: got %b want 0", switch_p_o); else passed++;
    release_reset();
  endtask

  task automatic test_qualify();
    run_win(20, 0);
    checks++; if (tgl_cnt_o !== 16'd20) $display("FAIL q1_tgl: got %0d want 20", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b1) $display("FAIL q1_ok: got %b want 1", ext_ok_o); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL q1_state: got %0d want 0", state_o); else passed++;
    run_win(20, 0);
    checks++; if (sel_o !== 1'b0) $display("FAIL q2_sel: got %b want 0", sel_o); else passed++;
    run_win(20, 0);
    checks++; if (state_o !== 2'd1) $display("FAIL q3_state: got %0d want 1", state_o); else passed++;
    checks++; if (sel_o !== 1'b1) $display("FAIL q3_sel: got %b want 1", sel_o); else passed++;
    checks++; if (switch_p_o !== 1'b1) $display("FAIL q3_sw: got %b want 1", switch_p_o); else passed++;
    checks++; if (tgl_cnt_o !== 16'd20) $display("FAIL q3_tgl: got %0d want 20", tgl_cnt_o); else passed++;
    checks++; if (pulse_cnt - pulse_base !== 1) $display("FAIL q3_pulses: got %0d want 1", pulse_cnt - pulse_base); else passed++;
  endtask

  task automatic test_fallback();
    run_win(0, 0);
    checks++; if (tgl_cnt_o !== 16'd0) $display("FAIL fb_tgl: got %0d want 0", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b0) $display("FAIL fb_ok: got %b want 0", ext_ok_o); else passed++;
    checks++; if (state_o !== 2'd2) $display("FAIL fb_state: got %0d want 2", state_o); else passed++;
    checks++; if (sel_o !== 1'b0) $display("FAIL fb_sel: got %b want 0", sel_o); else passed++;
    checks++; if (switch_p_o !== 1'b1) $display("FAIL fb_sw: got %b want 1", switch_p_o); else passed++;
    checks++; if (pulse_cnt - pulse_base !== 2) $display("FAIL fb_pulses: got %0d want 2", pulse_cnt - pulse_base); else passed++;
    run_win(20, 0);
    checks++; if (state_o !== 2'd2) $display("FAIL hold1_state: got %0d want 2", state_o); else passed++;
    run_win(20, 0);
    checks++; if (state_o !== 2'd0) $display("FAIL hold2_state: got %0d want 0", state_o); else passed++;
    run_win(20, 0);
    run_win(20, 0);
    checks++; if (state_o !== 2'd0) $display("FAIL rq2_state: got %0d want 0", state_o); else passed++;
    run_win(20, 0);
    checks++; if (state_o !== 2'd1) $display("FAIL rq3_state: got %0d want 1", state_o); else passed++;
    checks++; if (sel_o !== 1'b1) $display("FAIL rq3_sel: got %b want 1", sel_o); else passed++;
  endtask

  task automatic test_qual_break();
    run_win(0, 0);
    run_win(0, 0);
    run_win(0, 0);
    checks++; if (state_o !== 2'd0) $display("FAIL qb_local: got %0d want 0", state_o); else passed++;
    run_win(20, 0);
    run_win(20, 0);
    run_win(5, 0);
    checks++; if (tgl_cnt_o !== 16'd5) $display("FAIL qb_tgl5: got %0d want 5", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b0) $display("FAIL qb_ok5: got %b want 0", ext_ok_o); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL qb_state3: got %0d want 0", state_o); else passed++;
    run_win(20, 0);
    run_win(20, 0);
    checks++; if (state_o !== 2'd0) $display("FAIL qb_state5: got %0d want 0", state_o); else passed++;
    run_win(20, 0);
    checks++; if (state_o !== 2'd1) $display("FAIL qb_state6: got %0d want 1", state_o); else passed++;
  endtask

  task automatic test_boundaries();
    run_win(10, 0);
    checks++; if (tgl_cnt_o !== 16'd10) $display("FAIL b10_tgl: got %0d want 10", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b1) $display("FAIL b10_ok: got %b want 1", ext_ok_o); else passed++;
    run_win(30, 0);
    checks++; if (tgl_cnt_o !== 16'd30) $display("FAIL b30_tgl: got %0d want 30", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b1) $display("FAIL b30_ok: got %b want 1", ext_ok_o); else passed++;
    checks++; if (state_o !== 2'd1) $display("FAIL b30_state: got %0d want 1", state_o); else passed++;
    run_win(31, 0);
    checks++; if (tgl_cnt_o !== 16'd31) $display("FAIL b31_tgl: got %0d want 31", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b0) $display("FAIL b31_ok: got %b want 0", ext_ok_o); else passed++;
    checks++; if (state_o !== 2'd2) $display("FAIL b31_state: got %0d want 2", state_o); else passed++;
    run_win(9, 0);
    checks++; if (tgl_cnt_o !== 16'd9) $display("FAIL b9_tgl: got %0d want 9", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b0) $display("FAIL b9_ok: got %b want 0", ext_ok_o); else passed++;
    run_win(9, 1);
    checks++; if (tgl_cnt_o !== 16'd10) $display("FAIL term_tgl: got %0d want 10", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b1) $display("FAIL term_ok: got %b want 1", ext_ok_o); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL term_state: got %0d want 0", state_o); else passed++;
    run_win(9, 0);
    checks++; if (tgl_cnt_o !== 16'd9) $display("FAIL nocarry_tgl: got %0d want 9", tgl_cnt_o); else passed++;
  endtask

  task automatic test_force();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 10) begin
        force_en = 1'b1;
        force_sel = 1'b1;
      end
      if (i == 11) begin
        checks++; if (sel_o !== 1'b1) $display("FAIL frc_sel: got %b want 1", sel_o); else passed++;
        checks++; if (switch_p_o !== 1'b1) $display("FAIL frc_sw: got %b want 1", switch_p_o); else passed++;
        checks++; if (state_o !== 2'd0) $display("FAIL frc_state: got %0d want 0", state_o); else passed++;
      end
      if (i == 12) begin
        checks++; if (switch_p_o !== 1'b0) $display("FAIL frc_sw_end: got %b want 0", switch_p_o); else passed++;
      end
      if (i == 20) force_en = 1'b0;
      if (i == 21) begin
        checks++; if (sel_o !== 1'b0) $display("FAIL rel_sel: got %b want 0", sel_o); else passed++;
        checks++; if (switch_p_o !== 1'b1) $display("FAIL rel_sw: got %b want 1", switch_p_o); else passed++;
      end
    end
    #1;
    force_sel = 1'b0;
    checks++; if (state_o !== 2'd0) $display("FAIL frc_win_state: got %0d want 0", state_o); else passed++;
  endtask

  task automatic test_force_vs_fsm();
    int p0;
    run_win(20, 0);
    run_win(20, 0);
    force_en = 1'b1;
    run_win(20, 0);
    checks++; if (state_o !== 2'd1) $display("FAIL fvf_state: got %0d want 1", state_o); else passed++;
    checks++; if (sel_o !== 1'b0) $display("FAIL fvf_sel: got %b want 0", sel_o); else passed++;
    p0 = pulse_cnt;
    force_en = 1'b0;
    run_win(20, 0);
    checks++; if (sel_o !== 1'b1) $display("FAIL fvf_rel_sel: got %b want 1", sel_o); else passed++;
    checks++; if (pulse_cnt - p0 !== 1) $display("FAIL fvf_pulses: got %0d want 1", pulse_cnt - p0); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i % 3 == 0) ext_tgl = ~ext_tgl;
    end
    #3;
    arst_n = 1'b0;
    ext_tgl = 1'b0;
    #1;
    checks++; if (sel_o !== 1'b0) $display("FAIL mrst_sel: got %b want 0", sel_o); else passed++;
    checks++; if (state_o !== 2'd0) $display("FAIL mrst_state: got %0d want 0", state_o); else passed++;
    checks++; if (tgl_cnt_o !== 16'd0) $display("FAIL mrst_tgl: got %0d want 0", tgl_cnt_o); else passed++;
    checks++; if (ext_ok_o !== 1'b0) $display("FAIL mrst_ok: got %b want 0", ext_ok_o); else passed++;
    release_reset();
    run_win(20, 0);
    run_win(20, 0);
    checks++; if (sel_o !== 1'b0) $display("FAIL mrst_q2_sel: got %b want 0", sel_o); else passed++;
    run_win(20, 0);
    checks++; if (sel_o !== 1'b1) $display("FAIL mrst_q3_sel: got %b want 1", sel_o); else passed++;
    checks++; if (state_o !== 2'd1) $display("FAIL mrst_q3_state: got %0d want 1", state_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_fallback();
    test_qual_break();
    test_boundaries();
    test_force();
    test_force_vs_fsm();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
